// File: rtl/ddr2_cmd_ctrl_pkg.sv
// Shared command encodings, controller states, request record and timing defaults
// for the closed-page DDR2 command controller.
package ddr2_cmd_ctrl_pkg;

  localparam int TW            = 5;
  localparam int DEF_T_INIT    = 4;
  localparam int DEF_T_RCD     = 3;
  localparam int DEF_RD_SAMPLE = 9;
  localparam int DEF_RD_BUSY   = 13;
  localparam int DEF_T_WR      = 3;
  localparam int DEF_T_RP      = 3;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_NOP = 4'b0111,
    CMD_ACT = 4'b0011,
    CMD_RD  = 4'b0101,
    CMD_WR  = 4'b0100,
    CMD_PRE = 4'b0010
  } ddr2_cmd_t;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACT,
    ST_TRCD,
    ST_RD,
    ST_RDWAIT,
    ST_WR,
    ST_WSTRB,
    ST_TWR,
    ST_PRE,
    ST_TRP,
    ST_RESP
  } ddr2_ctrl_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [15:0] wdata;
  } ddr2_req_t;

  // A state that must last n cycles loads n-1 and leaves when the timer reads 0.
  function automatic logic [TW-1:0] waitLoad(input int n);
    return TW'(n - 1);
  endfunction

endpackage

// File: rtl/ddr2_wait_timer.sv
// Loadable down-counter used for every controller wait; done while the count is zero.
module ddr2_wait_timer
  import ddr2_cmd_ctrl_pkg::*;
(
  input  logic          i_ck,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_loadVal,
  output logic [TW-1:0] o_count,
  output logic          o_done
);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_ck or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/ddr2_cmd_ctrl.sv
// Closed-page DDR2 command controller: one ACT -> RD/WR -> PRE sequence per host
// request, with registered command/address/data pins and clock-counted waits.
module ddr2_cmd_ctrl
  import ddr2_cmd_ctrl_pkg::*;
#(
  parameter int T_INIT    = DEF_T_INIT,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int RD_SAMPLE = DEF_RD_SAMPLE,
  parameter int RD_BUSY   = DEF_RD_BUSY,
  parameter int T_WR      = DEF_T_WR,
  parameter int T_RP      = DEF_T_RP
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_bank,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [15:0] resp_rdata,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  inout  wire  [15:0] dq,
  inout  wire  [1:0]  dqs,
  inout  wire  [1:0]  dqs_n,
  output logic [1:0]  dm_rdqs,
  output logic        odt
);

  ddr2_ctrl_state_t r_state, w_nextState;
  ddr2_req_t        r_req, w_reqIn, w_req;
  ddr2_cmd_t        w_cmd;

  logic [3:0]    r_cmd;
  logic          r_cke, r_ready, r_respValid, r_respWe;
  logic [15:0]   r_respRdata;
  logic [1:0]    r_ba, w_ba;
  logic [12:0]   r_addr, w_addr;
  logic [15:0]   r_dq, w_dq;
  logic          r_dqOe, w_dqOe;
  logic [1:0]    r_dqs, w_dqs;
  logic          r_dqsOe, w_dqsOe;
  logic          w_load, w_timerDone, w_accept, w_capture;
  logic [TW-1:0] w_loadVal, w_timerCount;

  ddr2_wait_timer u_timer (
    .i_ck      (ck),
    .i_reset   (reset),
    .i_load    (w_load),
    .i_loadVal (w_loadVal),
    .o_count   (w_timerCount),
    .o_done    (w_timerDone)
  );

  assign w_reqIn  = {req_we, req_bank, req_row, req_col, req_wdata};
  assign w_accept = (r_state == ST_IDLE) && req_valid;
  // The ACT issued on the acceptance edge must use the live request fields.
  assign w_req    = (r_state == ST_IDLE) ? w_reqIn : r_req;
  // The timer reads RD_BUSY-RD_SAMPLE during cycle READ+RD_SAMPLE-1.
  assign w_capture = (r_state == ST_RDWAIT) &&
                     (w_timerCount == TW'(RD_BUSY - RD_SAMPLE));

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadVal   = '0;
    case (r_state)
      ST_INIT: begin
        if (!r_cke) begin
          w_load    = 1'b1;
          w_loadVal = waitLoad(T_INIT);
        end else if (w_timerDone) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE:   if (req_valid) w_nextState = ST_ACT;
      ST_ACT: begin
        if (T_RCD > 1) begin
          w_nextState = ST_TRCD;
          w_load      = 1'b1;
          w_loadVal   = waitLoad(T_RCD - 1);
        end else begin
          w_nextState = r_req.we ? ST_WR : ST_RD;
        end
      end
      ST_TRCD:   if (w_timerDone) w_nextState = r_req.we ? ST_WR : ST_RD;
      ST_RD: begin
        w_nextState = ST_RDWAIT;
        w_load      = 1'b1;
        w_loadVal   = waitLoad(RD_BUSY - 1);
      end
      ST_RDWAIT: if (w_timerDone) w_nextState = ST_PRE;
      ST_WR:     w_nextState = ST_WSTRB;
      ST_WSTRB: begin
        w_nextState = ST_TWR;
        w_load      = 1'b1;
        w_loadVal   = waitLoad(T_WR);
      end
      ST_TWR:    if (w_timerDone) w_nextState = ST_PRE;
      ST_PRE: begin
        w_nextState = ST_TRP;
        w_load      = 1'b1;
        w_loadVal   = waitLoad(T_RP);
      end
      ST_TRP:    if (w_timerDone) w_nextState = ST_RESP;
      ST_RESP:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_INIT;
    endcase
  end

  // Pin values are those of the state being entered, so they appear registered.
  always_comb begin
    w_cmd   = CMD_NOP;
    w_ba    = r_ba;
    w_addr  = r_addr;
    w_dq    = r_dq;
    w_dqOe  = 1'b0;
    w_dqs   = 2'b00;
    w_dqsOe = 1'b0;
    case (w_nextState)
      ST_ACT: begin
        w_cmd  = CMD_ACT;
        w_ba   = w_req.bank;
        w_addr = w_req.row;
      end
      ST_RD: begin
        w_cmd  = CMD_RD;
        w_ba   = w_req.bank;
        w_addr = {3'b000, w_req.col};
      end
      ST_WR: begin
        w_cmd   = CMD_WR;
        w_ba    = w_req.bank;
        w_addr  = {3'b000, w_req.col};
        w_dq    = w_req.wdata;
        w_dqOe  = 1'b1;
        w_dqsOe = 1'b1;
      end
      ST_WSTRB: begin
        w_dqOe  = 1'b1;
        w_dqs   = 2'b11;
        w_dqsOe = 1'b1;
      end
      ST_PRE: begin
        w_cmd  = CMD_PRE;
        w_ba   = w_req.bank;
        w_addr = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_req       <= '0;
      r_cke       <= 1'b0;
      r_cmd       <= 4'b1111;
      r_ba        <= '0;
      r_addr      <= '0;
      r_dq        <= '0;
      r_dqOe      <= 1'b0;
      r_dqs       <= 2'b00;
      r_dqsOe     <= 1'b0;
      r_ready     <= 1'b0;
      r_respValid <= 1'b0;
      r_respWe    <= 1'b0;
      r_respRdata <= '0;
    end else begin
      r_state     <= w_nextState;
      r_cke       <= 1'b1;
      r_cmd       <= w_cmd;
      r_ba        <= w_ba;
      r_addr      <= w_addr;
      r_dq        <= w_dq;
      r_dqOe      <= w_dqOe;
      r_dqs       <= w_dqs;
      r_dqsOe     <= w_dqsOe;
      r_ready     <= (w_nextState == ST_IDLE);
      r_respValid <= (w_nextState == ST_RESP);
      if (w_nextState == ST_RESP) r_respWe <= r_req.we;
      if (w_accept) r_req <= w_reqIn;
      if (w_capture) r_respRdata <= dq;
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_respValid;
  assign resp_we    = r_respWe;
  assign resp_rdata = r_respRdata;
  assign cke        = r_cke;
  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign ba         = r_ba;
  assign addr       = r_addr;
  assign dq         = r_dqOe  ? r_dq   : 16'hzzzz;
  assign dqs        = r_dqsOe ? r_dqs  : 2'bzz;
  assign dqs_n      = r_dqsOe ? ~r_dqs : 2'bzz;
  assign dm_rdqs    = 2'b00;
  assign odt        = 1'b0;

endmodule

// File: tb/tb_ddr2_cmd_ctrl.sv
// Directed self-checking bench for ddr2_cmd_ctrl: init, write, read-back,
// back-to-back writes, ignored request and mid-operation reset.
module tb_ddr2_cmd_ctrl;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                         WR = 4'b0100, PRE = 4'b0010;

  logic        ck = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [1:0]  req_bank = '0;
  logic [12:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_we, cke, cs_n, ras_n, cas_n, we_n, odt;
  logic [15:0] resp_rdata;
  logic [1:0]  ba, dm_rdqs;
  logic [12:0] addr;
  wire  [15:0] dq;
  wire  [1:0]  dqs, dqs_n;
  logic [15:0] tbDq = '0;
  logic        tbDqOe = 1'b0;
  logic [3:0]  cmdNow;
  int          vectors = 0;
  int          miscompares = 0;

  assign dq     = tbDqOe ? tbDq : 16'hzzzz;
  assign cmdNow = {cs_n, ras_n, cas_n, we_n};

  always #5 ck = ~ck;

  ddr2_cmd_ctrl dut (
    .ck(ck), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dq(dq), .dqs(dqs), .dqs_n(dqs_n),
    .dm_rdqs(dm_rdqs), .odt(odt)
  );

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] bank, input logic [12:0] row,
                               input logic [9:0] col, input logic [15:0] wdata);
    req_we = we; req_bank = bank; req_row = row; req_col = col; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] expCmd,
                            input logic expReady, input logic expResp);
    checkOutput({tag, "_cmd"}, cmdNow, expCmd);
    checkOutput({tag, "_ready"}, req_ready, expReady);
    checkOutput({tag, "_respv"}, resp_valid, expResp);
  endtask

  task automatic checkAct(input string tag, input logic [1:0] bank, input logic [12:0] row);
    checkCycle({tag, "_act"}, ACT, 1'b0, 1'b0);
    checkOutput({tag, "_act_ba"}, ba, bank);
    checkOutput({tag, "_act_addr"}, addr, row);
  endtask

  task automatic checkInit(input string tag);
    tick();
    checkOutput({tag, "_cke"}, cke, 1'b1);
    checkCycle({tag, "_first"}, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCycle({tag, "_wait"}, NOP, 1'b0, 1'b0);
      checkOutput({tag, "_dq_oe"}, dut.r_dqOe, 1'b0);
    end
    tick();
    checkCycle({tag, "_ready"}, NOP, 1'b1, 1'b0);
  endtask

  // Write timeline relative to ACT: WR +3, PRE +8, RESP +12, IDLE +13.
  task automatic writeBody(input string tag, input logic [1:0] bank, input logic [9:0] col,
                           input logic [15:0] wdata, input int pulseAt);
    logic [3:0] expCmd;
    for (int k = 1; k <= 13; k++) begin
      tick();
      expCmd = (k == 3) ? WR : (k == 8) ? PRE : NOP;
      checkCycle(tag, expCmd, k == 13, k == 12);
      if (k == 3) begin
        checkOutput({tag, "_wr_ba"}, ba, bank);
        checkOutput({tag, "_wr_addr"}, addr, {3'b000, col});
        checkOutput({tag, "_wr_dq"}, dq, wdata);
        checkOutput({tag, "_wr_dqs"}, dqs, 2'b00);
        checkOutput({tag, "_wr_dqsn"}, dqs_n, 2'b11);
      end
      if (k == 4) begin
        checkOutput({tag, "_strb_dq"}, dq, wdata);
        checkOutput({tag, "_strb_dqs"}, dqs, 2'b11);
        checkOutput({tag, "_strb_dqsn"}, dqs_n, 2'b00);
      end
      if (k == 5) begin
        checkOutput({tag, "_rel_dq"}, dut.r_dqOe, 1'b0);
        checkOutput({tag, "_rel_dqs"}, dut.r_dqsOe, 1'b0);
      end
      if (k == 8) begin
        checkOutput({tag, "_pre_ba"}, ba, bank);
        checkOutput({tag, "_pre_addr"}, addr, 13'h0000);
      end
      if (k == 12) checkOutput({tag, "_resp_we"}, resp_we, 1'b1);
      if (k == pulseAt) applyStimulus(1'b0, 2'd3, 13'h1111, 10'h222, 16'h0);
      if (k == pulseAt + 1) req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset and initialisation
    repeat (3) tick();
    checkOutput("rst_cke", cke, 1'b0);
    checkOutput("rst_cmd", cmdNow, 4'b1111);
    checkOutput("rst_ba_addr", {ba, addr}, 15'h0);
    checkOutput("rst_ready", req_ready, 1'b0);
    checkOutput("rst_resp", {resp_valid, resp_we, resp_rdata}, 18'h0);
    checkOutput("rst_tri", {dut.r_dqOe, dut.r_dqsOe}, 2'b00);
    checkOutput("tied_pins", {dm_rdqs, odt}, 3'b000);
    @(negedge ck) reset = 1'b0;
    checkInit("init");

    // Write; fields are scrambled after acceptance to prove they were latched
    applyStimulus(1'b1, 2'd1, 13'h0ABC, 10'h010, 16'hBEEF);
    tick();
    checkAct("wr", 2'd1, 13'h0ABC);
    req_valid = 1'b0;
    applyStimulus(1'b0, 2'd2, 13'h1555, 10'h3AA, 16'h1234);
    req_valid = 1'b0;
    writeBody("wr", 2'd1, 10'h010, 16'hBEEF, -10);

    // Read-back; RD at k=3, capture at end of RD+8, PRE at RD+13
    applyStimulus(1'b0, 2'd1, 13'h0ABC, 10'h010, 16'h0000);
    tick();
    checkAct("rd", 2'd1, 13'h0ABC);
    req_valid = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      checkCycle("rd", (k == 3) ? RD : (k == 16) ? PRE : NOP, k == 21, k == 20);
      if (k == 3) begin
        checkOutput("rd_ba", ba, 2'd1);
        checkOutput("rd_addr", addr, 13'h0010);
      end
      if (k == 11) begin
        checkOutput("rd_before_sample", resp_rdata, 16'h0000);
        tbDq = 16'hBEEF;
        tbDqOe = 1'b1;
      end
      if (k == 12) checkOutput("rd_sampled", resp_rdata, 16'hBEEF);
      if (k == 14) tbDqOe = 1'b0;
      if (k == 20) begin
        checkOutput("rd_resp_we", resp_we, 1'b0);
        checkOutput("rd_resp_data", resp_rdata, 16'hBEEF);
      end
    end

    // Back-to-back writes with req_valid held high
    applyStimulus(1'b1, 2'd2, 13'h0123, 10'h3FF, 16'h1234);
    tick();
    checkAct("b2b1", 2'd2, 13'h0123);
    applyStimulus(1'b1, 2'd3, 13'h1FFF, 10'h001, 16'hCAFE);
    writeBody("b2b1", 2'd2, 10'h3FF, 16'h1234, -10);
    tick();
    checkAct("b2b2", 2'd3, 13'h1FFF);
    req_valid = 1'b0;
    writeBody("b2b2", 2'd3, 10'h001, 16'hCAFE, -10);

    // Request pulsed during TRP is ignored
    applyStimulus(1'b1, 2'd0, 13'h0005, 10'h007, 16'h5555);
    tick();
    checkAct("ign", 2'd0, 13'h0005);
    req_valid = 1'b0;
    writeBody("ign", 2'd0, 10'h007, 16'h5555, 9);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkCycle("ign_after", NOP, 1'b1, 1'b0);
    end

    // Reset asserted while waiting out the read burst
    applyStimulus(1'b0, 2'd2, 13'h0042, 10'h024, 16'h0000);
    tick();
    checkAct("mid", 2'd2, 13'h0042);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkCycle("mid_pre", (k == 3) ? RD : NOP, 1'b0, 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_cke", cke, 1'b0);
    checkOutput("mid_rst_cmd", cmdNow, 4'b1111);
    checkOutput("mid_rst_ba_addr", {ba, addr}, 15'h0);
    checkOutput("mid_rst_ready", req_ready, 1'b0);
    checkOutput("mid_rst_resp", {resp_valid, resp_we, resp_rdata}, 18'h0);
    repeat (2) tick();
    checkOutput("mid_hold_cmd", cmdNow, 4'b1111);
    @(negedge ck) reset = 1'b0;
    checkInit("reinit");
    for (int k = 0; k < 15; k++) begin
      tick();
      checkCycle("mid_quiet", NOP, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
